// File: rtl/jk_flop_bank.sv
// ---------------------------------------------------------------------------
// jk_flop_bank
//
// A bank of WIDTH independent flip-flop channels that share one clock, one
// clock-enable and one function select. Each channel behaves as a JK, SR, D
// or T flop depending on mode. A parallel load overrides everything else.
// Also provided: a sticky per-channel flag for the forbidden SR input (S=R=1)
// and a saturating counter of channel bit changes.
//
// Parameters
//   WIDTH      number of flop channels (1..64)
//   CNT_W      width of the change counter (4..32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         bank clock-enable; q holds when low
//   mode       00 JK, 01 SR, 10 D, 11 T
//   j          per-channel J / S / D / T input
//   k          per-channel K / R input (unused in D and T modes)
//   load       synchronous parallel load, highest priority
//   load_data  parallel-load value
//   clr_flags  synchronous clear of the illegal flags
//   clr_cnt    synchronous clear of change_cnt
//   q          registered channel state
//   q_bar      combinational complement of q
//   illegal    sticky per-channel flag for SR input 11
//   change_cnt saturating count of q bit changes
// ---------------------------------------------------------------------------
module jk_flop_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_flags,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] change_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    // Popcount of up to 64 changed bits, and an adder wide enough that the
    // sum of counter and popcount can never overflow before it is clamped.
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal_reg;
    logic [WIDTH-1:0] illegal_next;
    logic [WIDTH-1:0] illegal_set;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [PC_W-1:0]  pop_cnt;
    logic [SUM_W-1:0] cnt_sum;

    mode_t mode_sel;
    assign mode_sel = mode_t'(mode);

    // Per-channel next-state logic.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_next;
            logic bit_set;

            always_comb begin
                bit_next = q_reg[gi];
                bit_set  = 1'b0;
                if (load) begin
                    bit_next = load_data[gi];
                end else if (en) begin
                    case (mode_sel)
                        MODE_JK: begin
                            case ({j[gi], k[gi]})
                                2'b01:   bit_next = 1'b0;
                                2'b10:   bit_next = 1'b1;
                                2'b11:   bit_next = ~q_reg[gi];
                                default: bit_next = q_reg[gi];
                            endcase
                        end
                        MODE_SR: begin
                            case ({j[gi], k[gi]})
                                2'b01:   bit_next = 1'b0;
                                2'b10:   bit_next = 1'b1;
                                // Forbidden combination: keep state, raise flag.
                                2'b11:   bit_set  = 1'b1;
                                default: bit_next = q_reg[gi];
                            endcase
                        end
                        MODE_D:  bit_next = j[gi];
                        MODE_T:  bit_next = q_reg[gi] ^ j[gi];
                        default: bit_next = q_reg[gi];
                    endcase
                end
            end

            assign q_next[gi]      = bit_next;
            assign illegal_set[gi] = bit_set;
        end
    endgenerate

    // A fresh SR-11 beats a simultaneous flag clear for that bit only.
    assign illegal_next = clr_flags ? illegal_set : (illegal_reg | illegal_set);

    // Count of bits that will change on this edge (load included).
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + PC_W'(q_next[i] ^ q_reg[i]);
        end
    end

    assign cnt_sum = {{PC_W{1'b0}}, cnt_reg} + {{CNT_W{1'b0}}, pop_cnt};

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_cnt) begin
            cnt_next = '0;
        end else if (cnt_sum > CNT_MAX) begin
            cnt_next = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            illegal_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            q_reg       <= q_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign q          = q_reg;
    assign q_bar      = ~q_reg;
    assign illegal    = illegal_reg;
    assign change_cnt = cnt_reg;

endmodule

// File: tb/tb_jk_flop_bank.sv
module tb_jk_flop_bank;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  j;
    logic [7:0]  k;
    logic        load;
    logic [7:0]  load_data;
    logic        clr_flags;
    logic        clr_cnt;

    logic [7:0]  q;
    logic [7:0]  q_bar;
    logic [7:0]  illegal;
    logic [15:0] change_cnt;

    // Second instance with a 4-bit counter, driven by the same stimulus,
    // used for saturation checks.
    logic [7:0]  q4;
    logic [7:0]  q_bar4;
    logic [7:0]  illegal4;
    logic [3:0]  change_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    jk_flop_bank #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_data  (load_data),
        .clr_flags  (clr_flags),
        .clr_cnt    (clr_cnt),
        .q          (q),
        .q_bar      (q_bar),
        .illegal    (illegal),
        .change_cnt (change_cnt)
    );

    jk_flop_bank #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_data  (load_data),
        .clr_flags  (clr_flags),
        .clr_cnt    (clr_cnt),
        .q          (q4),
        .q_bar      (q_bar4),
        .illegal    (illegal4),
        .change_cnt (change_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00;
        load = 1'b0; load_data = 8'h00; clr_flags = 1'b0; clr_cnt = 1'b0;

        // Reset state while rst_n is held low.
        #12;
        check_val("rst_q", q, 8'h00);
        check_val("rst_q_bar", q_bar, 8'hFF);
        check_val("rst_illegal", illegal, 8'h00);
        check_val("rst_cnt", change_cnt, 16'd0);
        #1 rst_n = 1'b1;

        // JK toggle on all bits for three edges.
        en = 1'b1; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick(); check_val("jk_tog1_q", q, 8'hFF);
        check_val("jk_tog1_q_bar", q_bar, 8'h00);
        tick(); check_val("jk_tog2_q", q, 8'h00);
        tick(); check_val("jk_tog3_q", q, 8'hFF);
        check_val("jk_tog3_cnt", change_cnt, 16'd24);
        check_val("jk_tog3_cnt4_sat", change_cnt4, 4'd15);

        // Counter clear with no changes.
        en = 1'b0; clr_cnt = 1'b1;
        tick(); check_val("clr_cnt", change_cnt, 16'd0);
        check_val("clr_cnt4", change_cnt4, 4'd0);
        check_val("clr_cnt_q_hold", q, 8'hFF);

        // T mode: climb to 14 then saturate via a partial add.
        clr_cnt = 1'b0; en = 1'b1; mode = 2'b11; j = 8'hFF;
        tick(); check_val("t_ff_q", q, 8'h00);
        j = 8'h3F;
        tick(); check_val("t_3f_q", q, 8'h3F);
        check_val("t_3f_cnt4", change_cnt4, 4'd14);
        j = 8'h0F;
        tick(); check_val("t_0f_q", q, 8'h30);
        check_val("sat_partial_cnt4", change_cnt4, 4'd15);
        check_val("sat_partial_cnt", change_cnt, 16'd18);
        tick(); check_val("sat_hold_cnt4", change_cnt4, 4'd15);
        check_val("sat_hold_cnt", change_cnt, 16'd22);
        clr_cnt = 1'b1; j = 8'hFF;
        tick(); check_val("clr_beats_inc_q", q, 8'hC0);
        check_val("clr_beats_inc_cnt", change_cnt, 16'd0);
        check_val("clr_beats_inc_cnt4", change_cnt4, 4'd0);

        // Load in SR mode with S=R=1 on some bits: load wins, no flag.
        clr_cnt = 1'b0; load = 1'b1; load_data = 8'hA5; mode = 2'b01; j = 8'h0F; k = 8'h0F;
        tick(); check_val("load_a5_q", q, 8'hA5);
        check_val("load_a5_cnt", change_cnt, 16'd4);
        check_val("load_no_flag", illegal, 8'h00);

        // SR forbidden input: hold and flag.
        load = 1'b0;
        tick(); check_val("sr11_q_hold", q, 8'hA5);
        check_val("sr11_illegal", illegal, 8'h0F);
        check_val("sr11_cnt", change_cnt, 16'd4);
        clr_flags = 1'b1; j = 8'h00; k = 8'h00;
        tick(); check_val("clr_flags", illegal, 8'h00);
        clr_flags = 1'b0; j = 8'h0F; k = 8'h0F;
        tick(); check_val("sr11_again", illegal, 8'h0F);
        clr_flags = 1'b1; j = 8'h01; k = 8'h01;
        tick(); check_val("set_beats_clr", illegal, 8'h01);
        check_val("set_beats_clr_q", q, 8'hA5);

        // SR set/reset.
        clr_flags = 1'b0; j = 8'hF0; k = 8'h0F;
        tick(); check_val("sr_setrst_q", q, 8'hF0);
        check_val("sr_setrst_cnt", change_cnt, 16'd8);
        check_val("sr_setrst_illegal", illegal, 8'h01);

        // D mode to zero, then load with en=0, then load against D mode.
        mode = 2'b10; j = 8'h00; k = 8'hFF;
        tick(); check_val("d_00_q", q, 8'h00);
        check_val("d_00_cnt", change_cnt, 16'd12);
        en = 1'b0; load = 1'b1; load_data = 8'h3C;
        tick(); check_val("load_en0_q", q, 8'h3C);
        check_val("load_en0_cnt", change_cnt, 16'd16);
        en = 1'b1; j = 8'hFF;
        tick(); check_val("load_beats_d_q", q, 8'h3C);
        check_val("load_beats_d_cnt", change_cnt, 16'd16);

        // JK set and reset on separate halves, then D load of a pattern.
        load = 1'b0; mode = 2'b00; j = 8'h0F; k = 8'hF0;
        tick(); check_val("jk_setrst_q", q, 8'h0F);
        check_val("jk_setrst_cnt", change_cnt, 16'd20);
        mode = 2'b10; j = 8'hA5;
        tick(); check_val("d_a5_q", q, 8'hA5);
        check_val("d_a5_cnt", change_cnt, 16'd24);

        // Disabled bank: nothing moves over four edges.
        en = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (e < 2) begin
                mode = 2'b11; j = 8'hFF; k = 8'h00;
            end else begin
                mode = 2'b01; j = 8'hFF; k = 8'hFF;
            end
            tick();
            check_val($sformatf("en0_q_%0d", e), q, 8'hA5);
            check_val($sformatf("en0_illegal_%0d", e), illegal, 8'h01);
            check_val($sformatf("en0_cnt_%0d", e), change_cnt, 16'd24);
        end

        // Drive q and illegal to all ones.
        en = 1'b1; mode = 2'b01; j = 8'hFF; k = 8'h00;
        tick(); check_val("sr_set_all_q", q, 8'hFF);
        check_val("sr_set_all_cnt", change_cnt, 16'd28);
        k = 8'hFF;
        tick(); check_val("sr_all_illegal", illegal, 8'hFF);

        // Asynchronous reset between edges, with load/clears active.
        load = 1'b1; load_data = 8'h81; clr_flags = 1'b1; clr_cnt = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_q", q, 8'h00);
        check_val("async_rst_q_bar", q_bar, 8'hFF);
        check_val("async_rst_illegal", illegal, 8'h00);
        check_val("async_rst_cnt", change_cnt, 16'd0);
        tick(); check_val("rst_overrides_load_q", q, 8'h00);
        check_val("rst_overrides_load_cnt", change_cnt, 16'd0);

        // Release away from the edge; first edge applies normal rules.
        #2 rst_n = 1'b1;
        clr_flags = 1'b0; clr_cnt = 1'b0;
        tick(); check_val("post_rst_load_q", q, 8'h81);
        check_val("post_rst_load_cnt", change_cnt, 16'd2);
        check_val("post_rst_load_cnt4", change_cnt4, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_flop_bank.md
JK_FLOP_BANK -- requirements
Module: jk_flop_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of independent flop channels (1..64).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the change counter (4..32).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the bank clock-enable; when low, q SHALL hold.
REQ-006 mode  input  2  SHALL select the channel function: 00 JK, 01 SR, 10 D, 11 T.
REQ-007 j  input  WIDTH  SHALL carry the per-channel J, S, D or T input, according to mode.
REQ-008 k  input  WIDTH  SHALL carry the per-channel K or R input; it SHALL be ignored in D and T modes.
REQ-009 load  input  1  SHALL request a synchronous parallel load.
REQ-010 load_data  input  WIDTH  SHALL be the parallel-load value.
REQ-011 clr_flags  input  1  SHALL be the synchronous clear for the illegal flags.
REQ-012 clr_cnt  input  1  SHALL be the synchronous clear for change_cnt.
REQ-013 q  output  WIDTH  SHALL be the registered channel state.
REQ-014 q_bar  output  WIDTH  SHALL be the bitwise complement of q, with no added latency.
REQ-015 illegal  output  WIDTH  SHALL be the per-channel sticky flag for SR input 11.
REQ-016 change_cnt  output  CNT_W  SHALL be the saturating count of channel bit changes.

Function
REQ-017 Each edge: load=1 SHALL set q<=load_data regardless of en and mode (priority 1).
REQ-018 load=0, en=1, mode JK: per bit, 00 SHALL hold, 01 SHALL give 0, 10 SHALL give 1, 11 SHALL toggle.
REQ-019 load=0, en=1, mode SR: per bit, 00 SHALL hold, 01 SHALL give 0, 10 SHALL give 1, 11 SHALL hold and set illegal[i].
REQ-020 load=0, en=1, mode D: q[i]<=j[i] SHALL apply.
REQ-021 load=0, en=1, mode T: q[i]<=q[i]^j[i] SHALL apply.
REQ-022 load=0, en=0: q SHALL hold and illegal SHALL not be set.
REQ-023 illegal[i] SHALL set only under REQ-019 and SHALL stay set until clr_flags or reset.
REQ-024 clr_flags together with a new SR-11 on the same edge: set SHALL win for that bit; other bits SHALL clear.
REQ-025 Each edge: change_cnt SHALL add popcount(q_next ^ q), including changes caused by load.
REQ-026 change_cnt arithmetic SHALL be unsigned and SHALL saturate at 2^CNT_W-1 with no wrap; a partial add SHALL clamp to that maximum.
REQ-027 clr_cnt=1 SHALL force change_cnt<=0 on that edge; clear SHALL win over that cycle's increment.
REQ-028 A mode change SHALL take effect on the same edge it is sampled; there SHALL be no pipeline and a q latency of 1 cycle.
REQ-029 All outputs except q_bar SHALL be registered; q_bar SHALL be combinational from q only.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force q=0, q_bar=all ones, illegal=0, change_cnt=0.
REQ-031 Reset assertion mid-operation SHALL override load, en and clears.
REQ-032 Reset deassertion SHALL be synchronised externally; the first active edge after release SHALL apply normal rules.

Verification
REQ-033 Reset, WIDTH=8: en=1, mode=00, j=8'hFF, k=8'hFF for 3 edges -> q 00->FF->00->FF, change_cnt=24.
REQ-034 mode=01, j=8'h0F, k=8'h0F, q=8'hA5 -> q holds A5, illegal=0F; next edge clr_flags=1 with j=k=0 -> illegal=00.
REQ-035 load=1, load_data=8'h3C, en=0 with q=00 -> q=3C, change_cnt +4; same edge in mode=10, j=FF -> load wins, q=3C.
REQ-036 CNT_W=4, change_cnt=14, mode=11, j=8'h0F -> change_cnt=15 (saturated); further toggles keep 15; clr_cnt=1 with toggles -> 0.
REQ-037 rst_n pulsed low between clock edges with q=FF, illegal=FF -> q=00, q_bar=FF, illegal=00, change_cnt=0 before the next edge.
REQ-038 en=0, mode=11, j=FF over 4 edges -> q, illegal and change_cnt all unchanged.
